// File: rtl/cordic_pkg.sv
// Shared constants for the CORDIC iteration controller: FSM encoding and
// rotation/vectoring mode values.
package cordic_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_ITER = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic MODE_ROT = 1'b0;
    localparam logic MODE_VEC = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_LOAD = ST_LOAD,
        S_ITER = ST_ITER,
        S_DONE = ST_DONE
    } cordic_state_e;

endpackage

// File: rtl/cordic_iter_cnt.sv
// Saturating up-counter with synchronous clear; term flags the MAX value,
// beyond which the count never advances.
module cordic_iter_cnt #(
    parameter int W   = 4,
    parameter int MAX = 15
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         term
);

    localparam logic [W-1:0] MAX_V = W'(MAX);
    localparam logic [W-1:0] ONE_V = W'(1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign term = (cnt_q == MAX_V);
    assign cnt  = cnt_q;

    // Next count: clear has priority, increment stops at MAX.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {W{1'b0}};
        end else if (inc && !term) begin
            cnt_d = cnt_q + ONE_V;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cordic_iter_ctrl.sv
// Sequencer for an iterative CORDIC datapath: load, ITER_N micro-rotations
// with per-step direction, then a completion pulse and sticky stop flag.
module cordic_iter_ctrl
    import cordic_pkg::*;
#(
    parameter int ITER_N = 16,
    parameter int IDX_W  = $clog2(ITER_N),
    parameter int CNT_W  = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             mode,
    input  logic             abort,
    input  logic             comp,
    output logic [IDX_W-1:0] i,
    output logic             load,
    output logic             en,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic             stop,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] counter
);

    cordic_state_e state_q;
    cordic_state_e state_d;
    logic          accept_s;
    logic          stop_q;
    logic          stop_d;
    logic          mode_q;
    logic          mode_d;
    logic          load_q;
    logic          en_q;
    logic          busy_q;
    logic          done_q;
    logic          idx_term_s;
    logic          idx_clr_s;
    logic          cyc_sat_s;
    logic          cyc_inc_s;

    // Next state; abort wins over start in IDLE and is ignored in DONE.
    always_comb begin
        state_d  = state_q;
        accept_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d  = S_LOAD;
                    accept_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (idx_term_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ITER;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sticky stop and latched mode; both change only on accept or completion.
    always_comb begin
        stop_d = stop_q;
        mode_d = mode_q;
        if (accept_s) begin
            stop_d = 1'b0;
            mode_d = mode;
        end else if (state_d == S_DONE) begin
            stop_d = 1'b1;
        end else begin
            stop_d = stop_q;
        end
    end

    // State and output registers, decoded from the next state so every
    // control output is a flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            stop_q  <= 1'b0;
            mode_q  <= MODE_ROT;
            load_q  <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stop_q  <= stop_d;
            mode_q  <= mode_d;
            load_q  <= (state_d == S_LOAD);
            en_q    <= (state_d == S_ITER);
            busy_q  <= (state_d == S_LOAD) || (state_d == S_ITER);
            done_q  <= (state_d == S_DONE);
        end
    end

    // Index runs only across consecutive ITER cycles, so it starts at 0 and
    // is back at 0 in every other state.
    assign idx_clr_s = (state_q != S_ITER) || (state_d != S_ITER);
    assign cyc_inc_s = ((state_q == S_LOAD) || (state_q == S_ITER)) && !abort && !cyc_sat_s;

    cordic_iter_cnt #(
        .W   (IDX_W),
        .MAX (ITER_N - 1)
    ) u_idx_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (idx_clr_s),
        .inc     (!idx_clr_s),
        .cnt     (i),
        .term    (idx_term_s)
    );

    cordic_iter_cnt #(
        .W   (CNT_W),
        .MAX ((1 << CNT_W) - 1)
    ) u_cyc_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (accept_s),
        .inc     (cyc_inc_s),
        .cnt     (counter),
        .term    (cyc_sat_s)
    );

    assign dir   = en_q & ((mode_q == MODE_VEC) ? comp : ~comp);
    assign load  = load_q;
    assign en    = en_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign stop  = stop_q;
    assign state = state_q;

endmodule

// File: tb/tb_cordic_iter_ctrl.sv
// Directed bench for cordic_iter_ctrl: ITER_N=16 instance for the main
// sequences, ITER_N=40 instance for counter saturation.
module tb_cordic_iter_ctrl;

    logic       clk;
    logic       reset_n;
    logic       start, mode, abort, comp;
    logic [3:0] i;
    logic       load, en, dir, busy, done, stop;
    logic [1:0] state;
    logic [4:0] counter;

    logic       start_b, mode_b, abort_b, comp_b;
    logic [5:0] i_b;
    logic       load_b, en_b, dir_b, busy_b, done_b, stop_b;
    logic [1:0] state_b;
    logic [4:0] counter_b;

    int n_pass  = 0;
    int n_total = 0;

    cordic_iter_ctrl #(.ITER_N(16), .CNT_W(5)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
        .abort(abort), .comp(comp), .i(i), .load(load), .en(en),
        .dir(dir), .busy(busy), .done(done), .stop(stop),
        .state(state), .counter(counter)
    );

    cordic_iter_ctrl #(.ITER_N(40), .CNT_W(5)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .mode(mode_b),
        .abort(abort_b), .comp(comp_b), .i(i_b), .load(load_b), .en(en_b),
        .dir(dir_b), .busy(busy_b), .done(done_b), .stop(stop_b),
        .state(state_b), .counter(counter_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One operation; abort_at >= 0 aborts at that index; extra pokes start
    // during ITER and abort during DONE, both of which must be ignored.
    task automatic do_op(input logic m, input int abort_at, input logic extra);
        logic exp_dir;
        mode  = m;
        start = 1'b1;
        step();
        start = 1'b0;
        mode  = ~m;
        check_eq("ld_load",  32'(load),    32'd1);
        check_eq("ld_state", 32'(state),   32'd1);
        check_eq("ld_i",     32'(i),       32'd0);
        check_eq("ld_cnt",   32'(counter), 32'd0);
        check_eq("ld_busy",  32'(busy),    32'd1);
        check_eq("ld_stop",  32'(stop),    32'd0);
        check_eq("ld_en",    32'(en),      32'd0);
        for (int n = 0; n < 16; n++) begin
            step();
            comp = n[0];
            #1;
            exp_dir = m ? n[0] : ~n[0];
            check_eq("it_en",    32'(en),    32'd1);
            check_eq("it_i",     32'(i),     32'(n));
            check_eq("it_state", 32'(state), 32'd2);
            check_eq("it_load",  32'(load),  32'd0);
            check_eq("it_dir",   32'(dir),   32'(exp_dir));
            if (extra && n == 5) start = 1'b1;
            if (extra && n == 6) start = 1'b0;
            if (n == abort_at) begin
                abort = 1'b1;
                step();
                abort = 1'b0;
                check_eq("ab_state", 32'(state),   32'd0);
                check_eq("ab_done",  32'(done),    32'd0);
                check_eq("ab_stop",  32'(stop),    32'd0);
                check_eq("ab_i",     32'(i),       32'd0);
                check_eq("ab_cnt",   32'(counter), 32'(n + 1));
                check_eq("ab_busy",  32'(busy),    32'd0);
                step();
                check_eq("ab_done2", 32'(done),    32'd0);
                check_eq("ab_st2",   32'(state),   32'd0);
                check_eq("ab_cnt2",  32'(counter), 32'(n + 1));
                return;
            end
        end
        step();
        check_eq("dn_done",  32'(done),    32'd1);
        check_eq("dn_state", 32'(state),   32'd3);
        check_eq("dn_stop",  32'(stop),    32'd1);
        check_eq("dn_cnt",   32'(counter), 32'd17);
        check_eq("dn_i",     32'(i),       32'd0);
        check_eq("dn_en",    32'(en),      32'd0);
        check_eq("dn_busy",  32'(busy),    32'd0);
        check_eq("dn_dir",   32'(dir),     32'd0);
        if (extra) abort = 1'b1;
        step();
        abort = 1'b0;
        check_eq("id_done",  32'(done),    32'd0);
        check_eq("id_state", 32'(state),   32'd0);
        check_eq("id_stop",  32'(stop),    32'd1);
        check_eq("id_cnt",   32'(counter), 32'd17);
        step();
        check_eq("id_hold",  32'(state),   32'd0);
    endtask

    initial begin
        int  cyc;
        int  maxi;
        bit  seen;
        logic [4:0] cnt_at_done;

        reset_n = 1'b0;
        start = 1'b0; mode = 1'b0; abort = 1'b0; comp = 1'b0;
        start_b = 1'b0; mode_b = 1'b0; abort_b = 1'b0; comp_b = 1'b0;
        step();
        check_eq("rst_state", 32'(state),   32'd0);
        check_eq("rst_i",     32'(i),       32'd0);
        check_eq("rst_cnt",   32'(counter), 32'd0);
        check_eq("rst_stop",  32'(stop),    32'd0);
        check_eq("rst_ctl",   32'({load, en, busy, done}), 32'd0);
        check_eq("rst_b",     32'(state_b), 32'd0);
        reset_n = 1'b1;
        step();
        check_eq("post_rst",  32'(state),   32'd0);

        do_op(1'b0, -1, 1'b0);
        do_op(1'b1, -1, 1'b0);
        do_op(1'b0,  7, 1'b0);
        do_op(1'b0, -1, 1'b1);

        // start and abort together in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        step();
        check_eq("sa_state", 32'(state), 32'd0);
        check_eq("sa_busy",  32'(busy),  32'd0);
        start = 1'b0;
        abort = 1'b0;
        step();
        check_eq("sa_state2", 32'(state), 32'd0);

        // start held high: back-to-back runs with one IDLE cycle between
        start = 1'b1;
        step();
        check_eq("bb_load", 32'(load), 32'd1);
        repeat (17) step();
        check_eq("bb_done",  32'(done),  32'd1);
        step();
        check_eq("bb_idle",  32'(state), 32'd0);
        step();
        check_eq("bb_load2", 32'(state), 32'd1);
        start = 1'b0;
        cyc  = 0;
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step();
            cyc++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("bb_seen", 32'(seen), 32'd1);
        check_eq("bb_lat",  32'(cyc),  32'd17);
        step();
        check_eq("bb_end",  32'(state), 32'd0);

        // asynchronous reset in the middle of a run
        mode  = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (11) step();
        check_eq("ar_i10", 32'(i), 32'd10);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("ar_state", 32'(state),   32'd0);
        check_eq("ar_i",     32'(i),       32'd0);
        check_eq("ar_cnt",   32'(counter), 32'd0);
        check_eq("ar_ctl",   32'({load, en, busy, done, stop}), 32'd0);
        step();
        check_eq("ar_done",  32'(done),    32'd0);
        reset_n = 1'b1;
        step();
        check_eq("ar_idle",  32'(state),   32'd0);
        check_eq("ar_done2", 32'(done),    32'd0);

        // ITER_N=40: counter saturates at 31, index reaches 39
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        cyc  = 0;
        maxi = 0;
        seen = 1'b0;
        cnt_at_done = 5'd0;
        for (int k = 0; k < 60; k++) begin
            step();
            cyc++;
            if (int'(i_b) > maxi) maxi = int'(i_b);
            if (done_b) begin
                seen = 1'b1;
                cnt_at_done = counter_b;
                break;
            end
        end
        check_eq("b_seen", 32'(seen),        32'd1);
        check_eq("b_lat",  32'(cyc),         32'd41);
        check_eq("b_maxi", 32'(maxi),        32'd39);
        check_eq("b_cnt",  32'(cnt_at_done), 32'd31);
        check_eq("b_stop", 32'(stop_b),      32'd1);
        step();
        check_eq("b_idle", 32'(state_b),     32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
